// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and helpers. Holds the receiver state
//                encoding and the bit-period calculation shared by uart_tx
//                and uart_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    // Number of clk cycles per bit on the line (integer division).
    function automatic int calc_pulse_width(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_sync
//  Description : Two-flop synchronizer for an asynchronous single-bit input,
//                plus a history flop for falling-edge detection. All flops
//                reset to 1 so an idle-high line shows no edge after reset.
//  Ports       : clk      - system clock
//                rstn     - asynchronous active-low reset
//                async_in - asynchronous input pin
//                sync_out - synchronized level (2 clk latency)
//                fall     - high for one cycle after sync_out goes 1 -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_sync (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync_out = r_sync;
    assign fall     = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver, LSB first, idle-high line, one stop bit.
//                Each bit is sampled at its centre using a counter clocked by
//                clk. Good bytes go to a single-entry valid/ready output
//                register; framing errors and overruns give one-cycle pulses.
//  Ports       : clk             - system clock
//                rstn            - asynchronous active-low reset
//                rx_sig          - asynchronous serial line, idle high
//                data_to_host    - received byte, stable while valid_to_host
//                valid_to_host   - output register holds an unconsumed byte
//                ready_from_host - host accepts the byte this cycle
//                frame_err       - pulse: stop bit sampled low, byte dropped
//                overrun         - pulse: good byte dropped, register full
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_sig,
    output logic [DATA_WIDTH-1:0] data_to_host,
    output logic                  valid_to_host,
    input  logic                  ready_from_host,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int c_PULSE_WIDTH = calc_pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int c_HALF        = c_PULSE_WIDTH / 2;
    localparam int c_CNT_W       = (c_PULSE_WIDTH > 1) ? $clog2(c_PULSE_WIDTH) : 1;
    localparam int c_IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(c_PULSE_WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(DATA_WIDTH - 1);

    logic w_sync;
    logic w_fall;

    uart_bit_sync u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .async_in (rx_sig),
        .sync_out (w_sync),
        .fall     (w_fall)
    );

    uart_rx_state_t        r_state;
    uart_rx_state_t        w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shreg_nxt;
    logic                  w_stop_sample;
    logic                  w_good;
    logic                  w_bad;
    logic                  w_xfer;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + c_CNT_W'(1);
        w_idx_nxt     = r_idx;
        w_shreg_nxt   = r_shreg;
        w_stop_sample = 1'b0;
        case (r_state)
            IDLE: begin
                // Only an edge starts a frame, so a held-low break never retriggers.
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    // Line back high at mid-start: a glitch, not a frame.
                    w_state_nxt = w_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == c_PULSE_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shreg_nxt[r_idx] = w_sync;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is seen.
                if (r_cnt == c_PULSE_LAST) begin
                    w_cnt_nxt     = '0;
                    w_stop_sample = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_good = w_stop_sample & w_sync;
    assign w_bad  = w_stop_sample & ~w_sync;
    assign w_xfer = valid_to_host & ready_from_host;

    // Single-entry output register. A byte being taken this cycle frees the
    // slot, so a new byte completing in the same cycle is loaded, not dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_to_host  <= '0;
            valid_to_host <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_err <= w_bad;
            overrun   <= 1'b0;
            if (w_good) begin
                if (!valid_to_host || w_xfer) begin
                    data_to_host  <= r_shreg;
                    valid_to_host <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                valid_to_host <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx. The DUT runs at
//                64 clk per bit (100 MHz clk, 1.5625 Mbit/s) so frames stay
//                short. Inputs change 2 ns after the rising edge; outputs
//                are observed on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CLK_FREQ = 100_000_000;
    localparam int c_BAUD     = 1_562_500;
    localparam int c_PW       = 64;
    // Start edge at pin -> valid visible: 2 sync flops + 1 IDLE->START cycle,
    // HALF (32) in START, 8 data bits and the stop bit of 64 each = 611 clk.
    localparam int c_LAT      = 611;

    logic       clk;
    logic       rstn;
    logic       rx_sig;
    logic [7:0] data_to_host;
    logic       valid_to_host;
    logic       ready_from_host;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    uart_rx #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (c_BAUD),
        .CLK_FREQ   (c_CLK_FREQ)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .rx_sig          (rx_sig),
        .data_to_host    (data_to_host),
        .valid_to_host   (valid_to_host),
        .ready_from_host (ready_from_host),
        .frame_err       (frame_err),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor: counts observed output activity.
    int         cyc = 0;
    int         n_valid_cyc = 0;
    int         n_xfer = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         rise_cyc = 0;
    logic       valid_q = 1'b0;
    logic [7:0] last_xfer = 8'h00;
    int         start_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid_to_host) n_valid_cyc++;
        if (valid_to_host && !valid_q) rise_cyc = cyc;
        valid_q = valid_to_host;
        if (valid_to_host && ready_from_host) begin
            n_xfer++;
            last_xfer = data_to_host;
        end
        if (frame_err) n_ferr++;
        if (overrun)   n_ovr++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hold_line(input logic level, input int cycles);
        rx_sig = level;
        repeat (cycles) tick();
    endtask

    // Drives one frame; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        start_cyc = cyc;
        hold_line(1'b0, c_PW);
        for (int i = 0; i < 8; i++) hold_line(d[i], c_PW);
        hold_line(stop_bit, c_PW);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx_sig = 1'b1;
        ready_from_host = 1'b0;
        repeat (3) tick();
        checks++; if (valid_to_host !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_to_host); end
        checks++; if (data_to_host !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_to_host); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        int v0, f0, o0;
        v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
        hold_line(1'b1, 50 * c_PW);
        checks++; if (n_valid_cyc - v0 !== 0) begin errors++; $display("FAIL idle_valid: got %0d cycles want 0", n_valid_cyc - v0); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL idle_ferr: got %0d want 0", n_ferr - f0); end
        checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL idle_ovr: got %0d want 0", n_ovr - o0); end
    endtask

    task automatic test_single_frame();
        int v0, x0;
        ready_from_host = 1'b1;
        v0 = n_valid_cyc; x0 = n_xfer;
        send_frame(8'hA5, 1'b1);
        hold_line(1'b1, 2 * c_PW);
        checks++; if (n_xfer - x0 !== 1) begin errors++; $display("FAIL a5_count: got %0d want 1", n_xfer - x0); end
        checks++; if (last_xfer !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", last_xfer); end
        checks++; if (n_valid_cyc - v0 !== 1) begin errors++; $display("FAIL a5_valid_width: got %0d want 1", n_valid_cyc - v0); end
        checks++; if (rise_cyc - start_cyc !== c_LAT) begin errors++; $display("FAIL a5_latency: got %0d want %0d", rise_cyc - start_cyc, c_LAT); end
        checks++; if (valid_to_host !== 1'b0) begin errors++; $display("FAIL a5_valid_after: got %b want 0", valid_to_host); end
    endtask

    task automatic test_glitch();
        int v0, f0, o0, x0;
        v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovr;
        hold_line(1'b0, 20);           // 200 ns, shorter than half a bit
        hold_line(1'b1, 3 * c_PW);
        checks++; if (n_valid_cyc - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", n_valid_cyc - v0); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); end
        checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL glitch_ovr: got %0d want 0", n_ovr - o0); end
        // Receiver must be back in IDLE: the next frame is received intact.
        x0 = n_xfer;
        send_frame(8'h96, 1'b1);
        hold_line(1'b1, 2 * c_PW);
        checks++; if (n_xfer - x0 !== 1 || last_xfer !== 8'h96) begin errors++; $display("FAIL glitch_next: got %0d bytes last %h want 1 byte 96", n_xfer - x0, last_xfer); end
    endtask

    task automatic test_frame_err();
        int v0, f0, x0;
        v0 = n_valid_cyc; f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles want 1", n_ferr - f0); end
        checks++; if (n_valid_cyc - v0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", n_valid_cyc - v0); end
        hold_line(1'b0, 20 * c_PW);    // break: line stays low, no new edge
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL break_ferr: got %0d want 1", n_ferr - f0); end
        checks++; if (n_valid_cyc - v0 !== 0) begin errors++; $display("FAIL break_valid: got %0d want 0", n_valid_cyc - v0); end
        hold_line(1'b1, 2 * c_PW);
        x0 = n_xfer;
        send_frame(8'h55, 1'b1);
        hold_line(1'b1, 2 * c_PW);
        checks++; if (n_xfer - x0 !== 1 || last_xfer !== 8'h55) begin errors++; $display("FAIL after_break: got %0d bytes last %h want 1 byte 55", n_xfer - x0, last_xfer); end
    endtask

    task automatic test_overrun();
        int o0, x0;
        ready_from_host = 1'b0;
        o0 = n_ovr; x0 = n_xfer;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        hold_line(1'b1, 2 * c_PW);
        checks++; if (data_to_host !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h want 11", data_to_host); end
        checks++; if (valid_to_host !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", valid_to_host); end
        checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL ovr_pulse: got %0d want 1", n_ovr - o0); end
        checks++; if (n_xfer - x0 !== 0) begin errors++; $display("FAIL ovr_noxfer: got %0d want 0", n_xfer - x0); end
        ready_from_host = 1'b1;
        tick();
        ready_from_host = 1'b0;
        tick();
        checks++; if (n_xfer - x0 !== 1 || last_xfer !== 8'h11) begin errors++; $display("FAIL ovr_drain: got %0d bytes last %h want 1 byte 11", n_xfer - x0, last_xfer); end
        checks++; if (valid_to_host !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear: got %b want 0", valid_to_host); end
    endtask

    task automatic test_back_to_back();
        int o0, x0;
        ready_from_host = 1'b0;
        send_frame(8'h81, 1'b1);
        hold_line(1'b1, 2 * c_PW);
        o0 = n_ovr; x0 = n_xfer;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                // Ready high only for the edge where 0x7E's stop bit is sampled.
                repeat (c_LAT - 1) tick();
                ready_from_host = 1'b1;
                tick();
                ready_from_host = 1'b0;
            end
        join
        checks++; if (n_xfer - x0 !== 1 || last_xfer !== 8'h81) begin errors++; $display("FAIL same_cycle_xfer: got %0d bytes last %h want 1 byte 81", n_xfer - x0, last_xfer); end
        checks++; if (valid_to_host !== 1'b1 || data_to_host !== 8'h7E) begin errors++; $display("FAIL same_cycle_load: got valid %b data %h want 1 7e", valid_to_host, data_to_host); end
        checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL same_cycle_ovr: got %0d want 0", n_ovr - o0); end
        ready_from_host = 1'b1;
        tick();
        ready_from_host = 1'b0;
        tick();
        checks++; if (last_xfer !== 8'h7E || valid_to_host !== 1'b0) begin errors++; $display("FAIL same_cycle_drain: got last %h valid %b want 7e 0", last_xfer, valid_to_host); end
    endtask

    task automatic test_reset_midframe();
        int v0, x0;
        ready_from_host = 1'b0;
        send_frame(8'h33, 1'b1);
        hold_line(1'b1, 2 * c_PW);
        checks++; if (valid_to_host !== 1'b1 || data_to_host !== 8'h33) begin errors++; $display("FAIL mid_pre: got valid %b data %h want 1 33", valid_to_host, data_to_host); end
        rx_sig = 1'b0;
        repeat (300) tick();
        rstn = 1'b0;
        #1;
        checks++; if (valid_to_host !== 1'b0 || data_to_host !== 8'h00) begin errors++; $display("FAIL mid_rst_out: got valid %b data %h want 0 00", valid_to_host, data_to_host); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got ferr %b ovr %b want 0 0", frame_err, overrun); end
        rx_sig = 1'b1;
        repeat (3) tick();
        rstn = 1'b1;
        v0 = n_valid_cyc;
        hold_line(1'b1, 12 * c_PW);
        checks++; if (n_valid_cyc - v0 !== 0) begin errors++; $display("FAIL mid_lost: got %0d valid cycles want 0", n_valid_cyc - v0); end
        ready_from_host = 1'b1;
        x0 = n_xfer;
        send_frame(8'h5A, 1'b1);
        hold_line(1'b1, 2 * c_PW);
        checks++; if (n_xfer - x0 !== 1 || last_xfer !== 8'h5A) begin errors++; $display("FAIL mid_recover: got %0d bytes last %h want 1 byte 5a", n_xfer - x0, last_xfer); end
    endtask

    initial begin
        rstn = 1'b0;
        rx_sig = 1'b1;
        ready_from_host = 1'b0;
        test_reset();
        test_idle();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
